// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Package : mem_arb_pkg
// Brief   : Shared types and constants for the two-port memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int   CNT_W     = 4;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Interface : mem_port_arbiter_if
// Brief     : Requester handshake bus plus the single memory port.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              owner;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory view
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
// ============================================================================
// Module : mem_arb_pick
// Brief  : Combinational winner select. MEM_ARB_RR_EN selects round-robin on
//          ties; otherwise the core port has fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       winner_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner_o = PORT_CORE;
    if (req_i == 2'b10) begin
      winner_o = PORT_DMA;
    end else if (req_i == 2'b11) begin
      winner_o = ~last_owner_i;
    end
  end
`else
  logic last_owner_unused;
  assign last_owner_unused = last_owner_i;

  always_comb begin
    winner_o = PORT_CORE;
    if (req_i == 2'b10) begin
      winner_o = PORT_DMA;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between the core (port 0) and loader/DMA
//          (port 1). Optional macro MEM_ARB_RR_EN enables round-robin ties.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              winner_d;
  logic              issue_d;

  mem_arb_pick u_pick (
    .req_i        (bus.req),
    .last_owner_i (owner_q),
    .winner_o     (winner_d)
  );

  // Issue is combinational in IDLE; rst gates it so reset drops mem_en at once.
  assign issue_d       = (state_q == IDLE) && (|bus.req) && !rst;
  assign bus.mem_en    = issue_d;
  assign bus.mem_we    = issue_d & bus.we[winner_d];
  assign bus.mem_addr  = issue_d ? (winner_d ? bus.addr1  : bus.addr0)  : '0;
  assign bus.mem_wdata = issue_d ? (winner_d ? bus.wdata1 : bus.wdata0) : '0;

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= PORT_CORE;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (|bus.req) begin
            owner_q <= winner_d;
            cnt_q   <= CNT_W'(MEM_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rdata_q <= bus.mem_rdata;
            ack_q   <= port_onehot(owner_q);
            state_q <= DONE;
          end
        end
        DONE: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Scoreboard bench for mem_port_arbiter with a latency-LAT memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: default contents are a fixed pattern, writes overlay it.
  bit   [31:0] wmem [0:63];
  bit   [63:0] wvalid;
  bit   [31:0] rd_pipe [0:LAT-1];

  function automatic logic [31:0] mem_init(input logic [5:0] i);
    return (i == 6'd4) ? 32'hDEADBEEF : (32'hC0DE0000 | {24'h0, i, 2'b00});
  endfunction

  function automatic logic [31:0] mem_rd(input logic [5:0] i);
    return wvalid[i] ? wmem[i] : mem_init(i);
  endfunction

  assign bus.mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      wmem[bus.mem_addr[7:2]]   <= bus.mem_wdata;
      wvalid[bus.mem_addr[7:2]] <= 1'b1;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_rd(bus.mem_addr[7:2]) : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          abort;
    bit          gap;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_en        = 0;
  int   n_ack       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push(input logic p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] r,
                      input bit ab, input bit gp);
    exp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = d; e.rdata = r;
    e.abort = ab; e.gap = gp;
    q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on ack.
  initial begin
    int   cyc      = 0;
    int   en_cyc   = 0;
    int   last_ack = -10;
    int   bcnt     = 0;
    bit   in_flight = 0;
    bit   exp_busy;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_ack", bus.ack, 2'b00);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        if (in_flight) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            check("discarded_is_abort", e.abort, 1'b1);
          end
          in_flight = 0;
          n_en--;
        end
        bcnt = 0;
      end else begin
        exp_busy = (bcnt > 0);
        check("ack_not_11", bus.ack == 2'b11, 1'b0);
        check("busy", bus.busy, exp_busy);
        if (bcnt > 0) bcnt--;
        if (bus.ack != 2'b00) begin
          n_ack++;
          if (!in_flight || q.size() == 0) begin
            flag("unexpected_ack");
          end else begin
            e = q.pop_front();
            check("ack_port", bus.ack, port_onehot(e.port));
            check("owner", bus.owner, e.port);
            check("ack_latency", cyc - en_cyc, LAT + 1);
            if (!e.we) check("rdata", bus.rdata, e.rdata);
            in_flight = 0;
            last_ack  = cyc;
          end
        end
        if (bus.mem_en) begin
          n_en++;
          if (exp_busy) flag("mem_en_outside_idle");
          if (in_flight || q.size() == 0) begin
            flag("unexpected_mem_en");
          end else begin
            check("mem_addr", bus.mem_addr, q[0].addr);
            check("mem_we", bus.mem_we, q[0].we);
            check("mem_wdata", bus.mem_wdata, q[0].wdata);
            if (q[0].gap) check("reissue_gap", cyc, last_ack + 1);
            in_flight = 1;
            en_cyc    = cyc;
            bcnt      = LAT + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input logic p, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
    if (p == PORT_CORE) begin
      bus.we[0] = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.we[1] = w; bus.addr1 = a; bus.wdata1 = d;
    end
    bus.req[p] = 1'b1;
  endtask

  task automatic wait_acks(input int n, input string tag);
    int got = 0;
    int k   = 0;
    while (got < n && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.ack != 2'b00) got++;
    end
    if (got < n) flag({"timeout_", tag});
    tick();
    bus.req = 2'b00;
  endtask

  task automatic single(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] r, input string tag);
    tick();
    push(p, w, a, d, r, 1'b0, 1'b0);
    set_port(p, w, a, d);
    wait_acks(1, tag);
  endtask

  initial begin
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_owner", bus.owner, 1'b0);
    check("reset_rdata", bus.rdata, 32'h0);
    tick();
    rst = 1'b0;

    // Reset lands mid-WAIT; req stays high and is re-served afterwards.
    tick();
    push(PORT_CORE, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 1'b0);
    push(PORT_CORE, 1'b0, 32'h08, 32'h0, 32'hC0DE0008, 1'b0, 1'b0);
    set_port(PORT_CORE, 1'b0, 32'h08, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_acks(1, "after_reset");

    single(PORT_CORE, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "core_read");
    single(PORT_DMA, 1'b1, 32'h40, 32'h1234, 32'h0, "dma_write");

    // Both ports stream; last owner is the DMA port at this point.
    tick();
`ifdef MEM_ARB_RR_EN
    push(PORT_CORE, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, 1'b0, 1'b0);
    push(PORT_DMA,  1'b0, 32'h24, 32'h0, 32'hC0DE0024, 1'b0, 1'b0);
    push(PORT_CORE, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, 1'b0, 1'b0);
    push(PORT_DMA,  1'b0, 32'h24, 32'h0, 32'hC0DE0024, 1'b0, 1'b0);
`else
    for (int i = 0; i < 4; i++)
      push(PORT_CORE, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, 1'b0, 1'b0);
`endif
    set_port(PORT_CORE, 1'b0, 32'h20, 32'h0);
    set_port(PORT_DMA, 1'b0, 32'h24, 32'h0);
    wait_acks(4, "stream");

    // Core holds req through its ack: re-issue right after the DONE cycle.
    tick();
    push(PORT_CORE, 1'b0, 32'h0C, 32'h0, 32'hC0DE000C, 1'b0, 1'b0);
    push(PORT_CORE, 1'b0, 32'h0C, 32'h0, 32'hC0DE000C, 1'b0, 1'b1);
    set_port(PORT_CORE, 1'b0, 32'h0C, 32'h0);
    wait_acks(2, "hold_req");

    single(PORT_CORE, 1'b1, 32'h44, 32'hCAFEF00D, 32'h0, "core_write");
    single(PORT_DMA, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, "dma_readback");
    single(PORT_CORE, 1'b0, 32'h40, 32'h0, 32'h00001234, "core_readback");

    repeat (3) tick();
    check("scoreboard_empty", q.size(), 0);
    check("en_count_vs_ack_count", n_en, n_ack);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
